// File: rtl/dmem_ctrl.sv
`timescale 1ns/1ps
// dmem_ctrl: data memory for the MEM stage of the MIPS datapath.
//
// Byte-addressed, word-organised storage with byte, half and word accesses.
// Loads are optionally sign-extended. Misaligned, out-of-range and
// illegal-size requests are flagged as faults and never touch the array.
// Each accepted request produces a registered response one cycle later.
// After reset a hardware sweep zeroes the array one word per cycle.
//
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   req_valid    request present
//   req_ready    request accepted this cycle (low while sweeping)
//   req_write    1 = store, 0 = load
//   req_size     0 byte, 1 half, 2 word, 3 illegal
//   req_signed   sign-extend byte/half loads
//   req_addr     byte address
//   req_wdata    right-aligned store data
//   rsp_valid    one-cycle response pulse
//   rsp_rdata    extended load data, 0 for stores and faults
//   rsp_fault    request faulted
//   busy         clear sweep in progress
module dmem_ctrl #(
  parameter int DEPTH          = 1024,
  parameter int ADDR_WIDTH     = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_fault,
  output logic                  busy
);

  localparam int DATA_W = 32;
  localparam int IDX_W  = $clog2(DEPTH);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
  localparam logic [0:0] ST_RESET = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Byte-lane write enables for a (legal) access of the given size.
  function automatic logic [3:0] lane_enables(input logic [1:0] size,
                                              input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << lane;
      SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate right-aligned store data across all lanes so that the byte
  // enables alone pick which copy lands in the array.
  function automatic logic [DATA_W-1:0] lane_data(input logic [1:0] size,
                                                  input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    case (size)
      SZ_BYTE: r = {4{d[7:0]}};
      SZ_HALF: r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // Select the addressed lane(s) of a word and extend to 32 bits.
  function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] word,
                                                    input logic [1:0] size,
                                                    input logic [1:0] lane,
                                                    input logic sgn);
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = sgn ? {{24{b[7]}}, b} : {24'b0, b};
      SZ_HALF: r = sgn ? {{16{h[15]}}, h} : {16'b0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  logic [0:0]        state;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] mem [DEPTH];

  // ---- stage p0: request decode, fault check, array access ----
  logic              accept_p0;
  logic              upper_bad_p0;
  logic              fault_p0;
  logic              store_p0;
  logic [IDX_W-1:0]  widx_p0;
  logic [1:0]        lane_p0;
  logic [3:0]        be_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [DATA_W-1:0] ldata_p0;

  // Address bits above the array are only present when ADDR_WIDTH is wider
  // than the array needs; a zero-width slice is avoided otherwise.
  generate
    if (ADDR_WIDTH > IDX_W + 2) begin : g_upper
      assign upper_bad_p0 = |req_addr[ADDR_WIDTH-1:IDX_W+2];
    end else begin : g_no_upper
      assign upper_bad_p0 = 1'b0;
    end
  endgenerate

  assign busy      = (state == ST_CLEAR);
  assign req_ready = !busy;
  assign accept_p0 = req_valid && req_ready;
  assign widx_p0   = req_addr[IDX_W+1:2];
  assign lane_p0   = req_addr[1:0];

  always_comb begin
    fault_p0 = upper_bad_p0;
    case (req_size)
      SZ_BYTE: fault_p0 = fault_p0;
      SZ_HALF: fault_p0 = fault_p0 || lane_p0[0];
      SZ_WORD: fault_p0 = fault_p0 || (lane_p0 != 2'b00);
      default: fault_p0 = 1'b1;
    endcase
  end

  assign store_p0 = accept_p0 && req_write && !fault_p0;
  assign be_p0    = lane_enables(req_size, lane_p0);
  assign wdata_p0 = lane_data(req_size, req_wdata);
  assign ldata_p0 = extend_load(mem[widx_p0], req_size, lane_p0, req_signed);

  // The array has no reset: only the sweep zeroes it. The sweep and normal
  // stores never coincide because requests are refused while sweeping.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[idx] <= '0;
    end else if (store_p0) begin
      for (int i = 0; i < 4; i++) begin
        if (be_p0[i]) mem[widx_p0][8*i +: 8] <= wdata_p0[8*i +: 8];
      end
    end
  end

  // ---- stage p1: registered response and sweep control ----
  logic              vld_p1;
  logic [DATA_W-1:0] rdata_p1;
  logic              fault_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_RESET;
      idx      <= '0;
      vld_p1   <= 1'b0;
      rdata_p1 <= '0;
      fault_p1 <= 1'b0;
    end else begin
      if (state == ST_CLEAR) begin
        idx <= idx + 1'b1;
        if (idx == IDX_W'(DEPTH - 1)) state <= ST_RUN;
      end
      vld_p1 <= accept_p0;
      if (accept_p0) begin
        fault_p1 <= fault_p0;
        rdata_p1 <= (fault_p0 || req_write) ? '0 : ldata_p0;
      end
    end
  end

  assign rsp_valid = vld_p1;
  assign rsp_rdata = rdata_p1;
  assign rsp_fault = fault_p1;

endmodule

// File: tb/tb_dmem_ctrl.sv
`timescale 1ns/1ps
module tb_dmem_ctrl;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int rsp_n  = 0;

  // Expected responses: {fault, rdata}
  logic [32:0] exp_q[$];

  dmem_ctrl #(
    .DEPTH(DEPTH),
    .ADDR_WIDTH(32),
    .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_size(req_size),
    .req_signed(req_signed),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_fault(rsp_fault),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Drive one request for one accept edge; leaves req_valid high so that
  // consecutive calls form back-to-back requests.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_flt);
    int w;
    w = 0;
    while (!req_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!req_ready) chk("ready_wait", {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
    exp_q.push_back({exp_flt, exp_rd});
    @(posedge clk); #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_write = 1'b0;
  endtask

  task automatic measure_sweep(output int n);
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Monitor: every response pops one expectation.
  initial begin : monitor
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp rsp_valid=1 rdata=0x%08h required no response", rsp_rdata);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("rsp%0d_rdata", rsp_n), rsp_rdata, e[31:0]);
          chk($sformatf("rsp%0d_fault", rsp_n), {31'b0, rsp_fault}, {31'b0, e[32]});
        end
        rsp_n++;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int n;
    rst = 1'b1;
    idle();
    req_size = 2'd0; req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_busy",  {31'b0, busy},      32'd1);
    chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata,          32'd0);
    chk("rst_fault", {31'b0, rsp_fault}, 32'd0);

    // First sweep after power-up
    @(negedge clk); rst = 1'b0;
    measure_sweep(n);
    chk("sweep1_cycles", n, DEPTH);
    chk("sweep1_ready", {31'b0, req_ready}, 32'd1);

    // Fill every word with junk, then reset and expect a full clear
    for (int i = 0; i < DEPTH; i++)
      issue(1'b1, 2'd2, 1'b0, 32'(i * 4), 32'hA5A5_0000 | 32'(i), 32'd0, 1'b0);
    idle();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    measure_sweep(n);
    chk("sweep2_cycles", n, DEPTH);
    chk("sweep2_ready", {31'b0, req_ready}, 32'd1);
    for (int i = 0; i < DEPTH; i++)
      issue(1'b0, 2'd2, 1'b0, 32'(i * 4), 32'd0, 32'd0, 1'b0);

    // Byte lanes
    issue(1'b1, 2'd2, 1'b0, 32'h08, 32'h1122_3344, 32'd0, 1'b0);
    issue(1'b1, 2'd0, 1'b0, 32'h0A, 32'h0000_00AA, 32'd0, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h08, 32'd0, 32'h11AA_3344, 1'b0);
    issue(1'b0, 2'd0, 1'b1, 32'h0A, 32'd0, 32'hFFFF_FFAA, 1'b0);
    issue(1'b0, 2'd0, 1'b0, 32'h0A, 32'd0, 32'h0000_00AA, 1'b0);
    issue(1'b0, 2'd0, 1'b1, 32'h0B, 32'd0, 32'h0000_0011, 1'b0);
    issue(1'b0, 2'd1, 1'b1, 32'h0A, 32'd0, 32'h0000_11AA, 1'b0);

    // Halves
    issue(1'b1, 2'd1, 1'b0, 32'h06, 32'h0000_8001, 32'd0, 1'b0);
    issue(1'b0, 2'd1, 1'b1, 32'h06, 32'd0, 32'hFFFF_8001, 1'b0);
    issue(1'b0, 2'd1, 1'b0, 32'h06, 32'd0, 32'h0000_8001, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h04, 32'd0, 32'h8001_0000, 1'b0);

    // Faults: none of these stores may land
    issue(1'b1, 2'd1, 1'b0, 32'h03, 32'h0000_DEAD, 32'd0, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 32'h02, 32'd0, 32'd0, 1'b1);
    issue(1'b1, 2'd3, 1'b0, 32'h08, 32'hFFFF_FFFF, 32'd0, 1'b1);
    issue(1'b1, 2'd2, 1'b0, 32'(DEPTH * 4), 32'hCAFE_BABE, 32'd0, 1'b1);
    issue(1'b0, 2'd0, 1'b1, 32'(DEPTH * 4 + 3), 32'd0, 32'd0, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 32'h08, 32'd0, 32'h11AA_3344, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h00, 32'd0, 32'd0, 1'b0);
    idle();
    @(posedge clk); #1;

    // Back-to-back store then load of the same word
    issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h0000_0005, 32'd0, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, 32'h0000_0005, 1'b0);
    idle();
    chk("b2b_second_valid", {31'b0, rsp_valid}, 32'd1);
    @(posedge clk); #1;
    chk("b2b_idle_valid", {31'b0, rsp_valid}, 32'd0);

    // Reset in the middle of the sweep restarts it
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("mid_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    measure_sweep(n);
    chk("sweep3_cycles", n, DEPTH);
    issue(1'b0, 2'd2, 1'b0, 32'h08, 32'd0, 32'd0, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, 32'd0, 1'b0);
    idle();

    repeat (3) @(posedge clk);
    #1;
    chk("pending_rsp", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised data memory for the MIPS datapath: byte-addressed, word-organised storage with byte/half/word accesses, sign or zero extension on loads, alignment and range fault detection, a registered one-cycle read response and a valid/ready request handshake. It replaces the flat word memory in the MEM stage. On reset it runs a hardware clear sweep instead of resetting the array in a single cycle.

## Interface
- DEPTH, 1024: number of 32-bit words; power of two, at least 4.
- ADDR_WIDTH, 32: width of the byte address; must be at least log2(DEPTH)+2.
- CLEAR_ON_RESET, 1: 1 runs a zeroing sweep after reset; 0 leaves array contents undefined.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal (faults).
- req_signed  in  1  sign-extend byte/half loads; ignored for stores and word loads.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  one-cycle pulse; response for the request accepted on the previous edge.
- rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and faults.
- rsp_fault  out  1  request was misaligned, out of range or illegal size.
- busy  out  1  clear sweep in progress.

## Operation
- A request is accepted when req_valid and req_ready are both high at a rising edge. req_ready = !busy. There is no response back-pressure, so throughput is one request per cycle.
- Word index = req_addr[log2(DEPTH)+1:2]. Lanes are little-endian: byte lane = addr[1:0], half lane = addr[1].
- Fault conditions:
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - req_size=3;
  - any req_addr bit above log2(DEPTH)+1 set.
- A faulting request does not access the array, and stores are suppressed. It still produces rsp_valid=1, rsp_fault=1, rsp_rdata=0.
- A legal store writes only the addressed byte lanes and leaves the other lanes unchanged. It returns rsp_valid=1, rsp_fault=0, rsp_rdata=0.
- A legal load selects the addressed lane(s). It zero-extends, or sign-extends from bit 7/15 when req_signed=1.
- FSM:
  - CLEAR: idx increments from 0, writing 0 to word idx each cycle. After writing DEPTH-1 it goes to RUN.
  - RUN: normal operation.
  - Reset forces CLEAR with idx=0 when CLEAR_ON_RESET=1, otherwise RUN.
  - Reset asserted mid-sweep restarts the sweep at 0.
- Array contents are not touched by the asynchronous reset itself; only the sweep clears them.

## Timing
- Reset values:
  - req_ready = 0 and busy = 1 if CLEAR_ON_RESET, else req_ready = 1 and busy = 0;
  - rsp_valid = 0, rsp_rdata = 0, rsp_fault = 0;
  - idx = 0.
- Clear duration: busy is high for exactly DEPTH cycles after rst deasserts. req_ready rises in cycle DEPTH+1 (counting the first post-reset edge as edge 1).
- Load latency is 1: accept at edge N, response registered at N and valid during cycle N+1.
- Store takes effect at edge N. A load accepted at edge N+1 returns the new data (read-after-write, no hazard).
- Stores write the array at the accept edge, not at the response edge.
- A load and a store accepted on consecutive edges to the same word each see a consistent array.
- rsp_valid is low in any cycle following an edge with no acceptance. rsp_rdata and rsp_fault hold their last value but are don't-care when rsp_valid=0.

## Test plan
- Reset sweep: CLEAR_ON_RESET=1, DEPTH=16, pre-load junk through a backdoor, pulse rst. Required: busy high for 16 cycles, then req_ready=1; word loads of 0x00..0x3C return 0.
- Byte lanes: store word 0x11223344 @0x8, store byte 0xAA @0xA, load word @0x8. Required: 0x11AA3344. Signed byte load @0xA returns 0xFFFFFFAA; unsigned returns 0x000000AA.
- Halves: store half 0x8001 @0x6. Signed half load @0x6 returns 0xFFFF8001; unsigned returns 0x00008001. Word @0x4 has bits [31:16]=0x8001.
- Faults: half @0x3, word @0x2, size=3, and word @(DEPTH*4). Required: rsp_fault=1, rsp_rdata=0, and a follow-up load shows memory unchanged.
- Back-to-back: store 0x5 @0x20 at edge N, load @0x20 at edge N+1. Required: rsp_valid on cycles N+1 and N+2; second response returns 0x5 with rsp_fault=0.
- Reset mid-sweep: assert rst at sweep cycle 7, release it. Required: the sweep restarts and busy stays high for a full DEPTH cycles from release.
